controle_display: RTL and testbench

Scan controller for a 4-digit multiplexed 7-segment display. It accepts a 16-bit value through a valid/ready handshake and double-buffers it so updates land only on frame boundaries. Each cycle it presents one hex nibble on `digito`, which feeds the `display7seg` decoder (active-low segments), and drives the matching active-low anode. Inter-digit blanking suppresses ghosting, and optional leading-zero suppression is supported.

---
 rtl/controle_display_if.sv | 27 ++
 rtl/controle_display.sv | 152 +++++++++++++++
 tb/tb_controle_display.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/controle_display_if.sv
// controle_display_if
//   Valid/ready load port of the 7-segment scan controller.
//   dado_in       : 16-bit value, nibble 0 is the rightmost digit
//   suprime_zeros : leading-zero suppression flag travelling with dado_in
//   dado_valido   : source holds a value (stays high, data stable, until accepted)
//   dado_pronto   : pending buffer empty; transfer when dado_valido & dado_pronto
//   master = value source, slave = controle_display
interface controle_display_if;
  logic [15:0] dado_in;
  logic        suprime_zeros;
  logic        dado_valido;
  logic        dado_pronto;

  modport master (
    output dado_in,
    output suprime_zeros,
    output dado_valido,
    input  dado_pronto
  );

  modport slave (
    input  dado_in,
    input  suprime_zeros,
    input  dado_valido,
    output dado_pronto
  );
endinterface

// File: rtl/controle_display.sv
// controle_display
//   Scan controller for a 4-digit multiplexed 7-segment display. A value
//   arrives through a valid/ready handshake into a pending buffer and is
//   copied into the scanned shadow register only at frame boundaries.
//   Each digit slot lasts DIV cycles; the first BLANK cycles keep all
//   anodes off to avoid ghosting.
//   Ports:
//     clock, reset : rising-edge clock, synchronous active-high reset
//     bus (slave)  : dado_in / suprime_zeros / dado_valido / dado_pronto
//     digito       : nibble of the scanned digit (to the display7seg decoder)
//     anodo        : active-low digit enables, bit i = digit i
//     quadro_fim   : one-cycle pulse in the first cycle of each new frame
//   All outputs are registered.
module controle_display #(
  parameter int DIV   = 50000,
  parameter int BLANK = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  controle_display_if.slave    bus,
  output logic [3:0]           digito,
  output logic [3:0]           anodo,
  output logic                 quadro_fim
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);

  typedef enum logic {APAGADO, ACESO} estado_t;

  estado_t       estado, estado_nx;
  logic          ativo;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0]    idx, idx_nx;
  logic          fim_quadro;
  logic [15:0]   exibido, exibido_nx;
  logic          sup_exib, sup_exib_nx;
  logic [15:0]   pendente;
  logic          sup_pend;
  logic          cheio, cheio_nx;
  logic          pronto;
  logic          xfer;
  logic [3:0]    digito_nx, anodo_nx;

  assign bus.dado_pronto = pronto;
  assign xfer            = bus.dado_valido & pronto;

  // Digit i (1..3) is blanked when it and every digit to its left are zero.
  function automatic logic suprimido(input logic [1:0] i, input logic [15:0] v,
                                     input logic s);
    logic r;
    case (i)
      2'd1:    r = (v[15:4] == 12'h000);
      2'd2:    r = (v[15:8] == 8'h00);
      2'd3:    r = (v[15:12] == 4'h0);
      default: r = 1'b0;
    endcase
    return s & r;
  endfunction

  // Scan position for the next cycle. The cycle after reset releases only
  // arms the scanner (ativo) so that position 0 is shown in the first
  // cycle whose outputs are computed out of reset.
  always_comb begin
    cnt_nx     = cnt;
    idx_nx     = idx;
    fim_quadro = 1'b0;
    if (ativo) begin
      if (cnt == CNT_MAX) begin
        cnt_nx     = '0;
        idx_nx     = idx + 2'd1;
        fim_quadro = (idx == 2'd3);
      end else begin
        cnt_nx = cnt + CW'(1);
      end
    end
  end

  // Double buffer: the frame-end load and a new transfer never coincide,
  // since a transfer needs cheio = 0 and the load needs cheio = 1.
  always_comb begin
    exibido_nx  = exibido;
    sup_exib_nx = sup_exib;
    cheio_nx    = cheio;
    if (fim_quadro && cheio) begin
      exibido_nx  = pendente;
      sup_exib_nx = sup_pend;
      cheio_nx    = 1'b0;
    end
    if (xfer) cheio_nx = 1'b1;
  end

  // FSM: state register
  always_ff @(posedge clock) begin
    if (reset) estado <= APAGADO;
    else       estado <= estado_nx;
  end

  // FSM: next state
  always_comb begin
    estado_nx = estado;
    case (estado)
      APAGADO: if (cnt_nx == CNT_BLANK) estado_nx = ACESO;
      ACESO:   if (cnt == CNT_MAX)      estado_nx = APAGADO;
      default: estado_nx = APAGADO;
    endcase
  end

  // FSM: outputs for the next cycle, registered below
  always_comb begin
    digito_nx = exibido_nx[{idx_nx, 2'b00} +: 4];
    anodo_nx  = 4'b1111;
    if (estado_nx == ACESO && !suprimido(idx_nx, exibido_nx, sup_exib_nx))
      anodo_nx = ~(4'b0001 << idx_nx);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ativo      <= 1'b0;
      cnt        <= '0;
      idx        <= 2'd0;
      exibido    <= 16'h0000;
      sup_exib   <= 1'b0;
      cheio      <= 1'b0;
      pronto     <= 1'b0;
      digito     <= 4'h0;
      anodo      <= 4'b1111;
      quadro_fim <= 1'b0;
    end else begin
      ativo      <= 1'b1;
      cnt        <= cnt_nx;
      idx        <= idx_nx;
      exibido    <= exibido_nx;
      sup_exib   <= sup_exib_nx;
      cheio      <= cheio_nx;
      pronto     <= ~cheio_nx;
      digito     <= digito_nx;
      anodo      <= anodo_nx;
      quadro_fim <= fim_quadro;
    end
  end

  // Pending data carries no reset; cheio qualifies it.
  always_ff @(posedge clock) begin
    if (xfer) begin
      pendente <= bus.dado_in;
      sup_pend <= bus.suprime_zeros;
    end
  end

endmodule

// File: tb/tb_controle_display.sv
// tb_controle_display
//   Directed bench for controle_display with DIV = 8, BLANK = 2.
//   A table of {value, suppression flag, expected anode pattern per digit}
//   drives full-frame comparisons; hand-written sequences cover reset,
//   backpressure, a transfer in the frame-end cycle and reset mid-frame.
module tb_controle_display;
  localparam int DIV   = 8;
  localparam int BLANK = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] digito;
  logic [3:0] anodo;
  logic       quadro_fim;

  controle_display_if bus ();

  controle_display #(.DIV(DIV), .BLANK(BLANK)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .digito     (digito),
    .anodo      (anodo),
    .quadro_fim (quadro_fim)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // an holds the active-phase anode pattern of digit i in an[4*i +: 4]
  typedef struct {
    logic [15:0] dado;
    logic        sup;
    logic [15:0] an;
  } vec_t;

  vec_t tbl[6];
  vec_t zero_v, v1111, v2222, v3c5a;

  function automatic vec_t mk(input logic [15:0] d, input logic s, input logic [15:0] an);
    vec_t v;
    v.dado = d;
    v.sup  = s;
    v.an   = an;
    return v;
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string nome, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nome, act, exp);
    end
  endtask

  // Hold valid until accepted; reports whether quadro_fim was high in the
  // accepting cycle.
  task automatic send(input logic [15:0] d, input logic s, output logic qf_acc);
    logic acc, q, ok;
    ok     = 1'b0;
    qf_acc = 1'b0;
    bus.dado_in       = d;
    bus.suprime_zeros = s;
    bus.dado_valido   = 1'b1;
    for (int i = 0; i < 100; i++) begin
      acc = bus.dado_pronto;
      q   = quadro_fim;
      tick();
      if (acc === 1'b1) begin
        ok     = 1'b1;
        qf_acc = q;
        break;
      end
    end
    bus.dado_valido = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: value %0h never accepted", d);
    end else begin
      check($sformatf("pronto_after_xfer_%0h", d), {31'd0, bus.dado_pronto}, 32'd0);
    end
  endtask

  task automatic wait_qf(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (quadro_fim === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_wait_quadro_fim: no pulse within 80 cycles", tag);
    end
  endtask

  // Checks one whole frame cycle by cycle, starting in the first cycle of
  // the idx-0 slot; ends in the first cycle of the following frame.
  task automatic check_frame(input vec_t v, input logic exp_qf, input logic exp_pronto,
                             input string tag);
    logic [3:0] exp_an;
    logic       qf_e;
    check({tag, "_pronto"}, {31'd0, bus.dado_pronto}, {31'd0, exp_pronto});
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < DIV; c++) begin
        exp_an = (c < BLANK) ? 4'b1111 : v.an[4*s +: 4];
        qf_e   = (s == 0 && c == 0) ? exp_qf : 1'b0;
        check($sformatf("%s_s%0d_c%0d {qf,dig,an}", tag, s, c),
              {23'd0, quadro_fim, digito, anodo},
              {23'd0, qf_e, v.dado[4*s +: 4], exp_an});
        tick();
      end
    end
  endtask

  initial begin
    logic q;
    bus.dado_valido   = 1'b0;
    bus.dado_in       = 16'h0000;
    bus.suprime_zeros = 1'b0;
    reset             = 1'b1;

    zero_v = mk(16'h0000, 1'b0, 16'h7BDE);
    v1111  = mk(16'h1111, 1'b0, 16'h7BDE);
    v2222  = mk(16'h2222, 1'b0, 16'h7BDE);
    v3c5a  = mk(16'h3C5A, 1'b0, 16'h7BDE);
    tbl[0] = mk(16'h1A2F, 1'b0, 16'h7BDE);
    tbl[1] = mk(16'h0005, 1'b1, 16'hFFFE);
    tbl[2] = mk(16'h0000, 1'b1, 16'hFFFE);
    tbl[3] = mk(16'h0500, 1'b1, 16'hFBDE);
    tbl[4] = mk(16'h0500, 1'b0, 16'h7BDE);
    tbl[5] = mk(16'h00F0, 1'b1, 16'hFFDE);

    // Reset held three cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("reset_c%0d {an,dig,pronto,qf}", i),
            {22'd0, anodo, digito, bus.dado_pronto, quadro_fim},
            {22'd0, 4'b1111, 4'h0, 1'b0, 1'b0});
    end
    reset = 1'b0;
    tick();
    check_frame(zero_v, 1'b0, 1'b1, "after_reset");

    // Table-driven loads
    for (int k = 0; k < 6; k++) begin
      send(tbl[k].dado, tbl[k].sup, q);
      wait_qf($sformatf("vec%0d", k));
      check_frame(tbl[k], 1'b1, 1'b1, $sformatf("vec%0d_%0h", k, tbl[k].dado));
    end

    // Backpressure: second value waits for the frame that shows the first
    send(16'h1111, 1'b0, q);
    send(16'h2222, 1'b0, q);
    check("bp_accept_with_quadro_fim", {31'd0, q}, 32'd1);
    check("bp_first_frame_digit", {28'd0, digito}, 32'h1);
    wait_qf("bp");
    check_frame(v2222, 1'b1, 1'b1, "bp_2222");

    // Transfer in the frame-end cycle
    for (int i = 0; i < 4*DIV - 1; i++) tick();
    check("fe_last_slot {pronto,dig,an}", {23'd0, bus.dado_pronto, digito, anodo},
          {23'd0, 1'b1, 4'h2, 4'b0111});
    bus.dado_in       = 16'h3C5A;
    bus.suprime_zeros = 1'b0;
    bus.dado_valido   = 1'b1;
    tick();
    bus.dado_valido   = 1'b0;
    check_frame(v2222, 1'b1, 1'b0, "fe_old");
    check_frame(v3c5a, 1'b1, 1'b1, "fe_new");

    // Reset during the digit-2 active phase, with a value still pending
    send(16'hBEEF, 1'b0, q);
    wait_qf("beef");
    send(16'h7777, 1'b0, q);
    for (int i = 1; i < 2*DIV + 3; i++) tick();
    check("beef_digit2 {dig,an}", {24'd0, digito, anodo}, {24'd0, 4'hE, 4'b1011});
    reset = 1'b1;
    tick();
    check("mid_reset {an,dig,pronto,qf}",
          {22'd0, anodo, digito, bus.dado_pronto, quadro_fim},
          {22'd0, 4'b1111, 4'h0, 1'b0, 1'b0});
    reset = 1'b0;
    tick();
    check_frame(zero_v, 1'b0, 1'b1, "mid_reset_f0");
    check_frame(zero_v, 1'b1, 1'b1, "mid_reset_f1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
